vram_write_scheduler: RTL and testbench
=======================================

VRAM_WRITE_SCHEDULER -- requirements
Module: vram_write_scheduler

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, VRAM address width.
REQ-002 SHALL have parameter DEPTH, default 4, write-buffer entries; power of two, 2..16.
REQ-003 SHALL have port clk  input  1  pixel clock, 12.5875 MHz; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port visible  input  1  high while the timing generator is in the active pixel region.
REQ-006 SHALL have port vsync  input  1  active-low vertical sync from the timing generator.
REQ-007 SHALL have port cpu_wr_valid  input  1  CPU write request.
REQ-008 SHALL have port cpu_wr_ready  output  1  buffer can accept a write.
REQ-009 SHALL have port cpu_wr_addr  input  ADDR_W  CPU write address.
REQ-010 SHALL have port cpu_wr_data  input  8  CPU write data.
REQ-011 SHALL have port vram_addr  output  ADDR_W  VRAM write address.
REQ-012 SHALL have port vram_wdata  output  8  VRAM write data.
REQ-013 SHALL have port vram_we  output  1  VRAM write strobe, one write per cycle.
REQ-014 SHALL have port gpu_owns  output  1  GPU read path owns VRAM.
REQ-015 SHALL have port pending  output  $clog2(DEPTH)+1  buffered write count.
REQ-016 SHALL have port vblank_irq  output  1  sticky frame interrupt.
REQ-017 SHALL have port irq_ack  input  1  clears vblank_irq.

Function
REQ-018 SHALL accept a CPU write on any clk edge where cpu_wr_valid && cpu_wr_ready, storing addr/data into a FIFO of DEPTH entries.
REQ-019 SHALL drive cpu_wr_ready = (pending < DEPTH); simultaneous push and pop when full SHALL NOT be accepted (ready is low when full).
REQ-020 SHALL keep a 3-state FSM: GPU, TURN, CPU.
REQ-021 SHALL transition GPU->TURN when visible==0; TURN->CPU when visible==0; TURN->GPU or CPU->GPU when visible==1.
REQ-022 SHALL drive gpu_owns=1 in GPU and TURN, 0 in CPU.
REQ-023 SHALL assert vram_we in a cycle only when state==CPU && visible==0 && pending!=0, popping the FIFO head that cycle.
REQ-024 SHALL present head entry on vram_addr/vram_wdata combinationally while vram_we=1; values don't-care otherwise.
REQ-025 SHALL never assert vram_we while visible==1, including the cycle visible rises in CPU state.
REQ-026 SHALL write in FIFO order; no reordering or coalescing.
REQ-027 SHALL update pending as +1 on push only, -1 on pop only, unchanged on both or neither.
REQ-028 SHALL allow push into an empty FIFO to be popped no earlier than the following cycle (no fall-through).
REQ-029 SHALL set vblank_irq on the first cycle vsync is sampled low after being high (registered previous vsync).
REQ-030 SHALL clear vblank_irq on irq_ack; if set event and irq_ack coincide, set SHALL win.
REQ-031 SHALL wrap FIFO read/write pointers modulo DEPTH.

Reset
REQ-032 SHALL, while rst high, force state=GPU, pending=0, FIFO pointers=0, vram_we=0, gpu_owns=1, vblank_irq=0, vsync history=1.
REQ-033 SHALL drive cpu_wr_ready=0 while rst is high and 1 the first cycle after.
REQ-034 SHALL discard buffered writes on reset asserted mid-drain; no vram_we in the reset cycle.

Verification
REQ-035 SHALL pass: 3 writes (0x010/0xAA, 0x011/0xBB, 0x012/0xCC) while visible=1 -> no vram_we, pending=3; visible falls -> TURN 1 cycle, then three consecutive vram_we in order, pending=0.
REQ-036 SHALL pass: DEPTH+1 back-to-back valid writes, visible=1 -> first DEPTH accepted, cpu_wr_ready=0 on 5th, pending=4.
REQ-037 SHALL pass: CPU state draining 4 entries, visible rises after 2 writes -> vram_we=0 that cycle, gpu_owns=1, pending=2; remaining 2 written next blanking after TURN.
REQ-038 SHALL pass: vsync 1->0 -> vblank_irq=1 next cycle, held through vsync low; irq_ack pulse -> 0; ack coincident with new falling edge -> stays 1.
REQ-039 SHALL pass: rst pulsed with pending=3 in CPU state -> next cycle pending=0, state GPU, vram_we=0, vblank_irq=0.
REQ-040 SHALL pass: push and pop in same cycle with pending=2 -> pending stays 2, data order preserved.

Source files
------------

// File: rtl/vram_write_scheduler.sv
// Buffers CPU writes to VRAM and drains them only during blanking. Writes are drained when the CPU owns VRAM.
// Latency: a buffered write is visible on vram_we no earlier than the cycle after it is accepted.
// Backpressure: cpu_wr_ready is low when the buffer is full or while rst is high.
//
// Ports:
//   clk, rst                  pixel clock, synchronous active-high reset
//   visible, vsync            timing generator status (vsync active-low)
//   cpu_wr_valid/ready/addr/data  CPU write request channel into the buffer
//   vram_addr/wdata/we        VRAM write port, one write per cycle
//   gpu_owns                  high while the GPU read path owns VRAM
//   pending                   number of buffered writes
//   vblank_irq, irq_ack       sticky frame interrupt and its clear
module vram_write_scheduler #(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     visible,
  input  logic                     vsync,
  input  logic                     cpu_wr_valid,
  output logic                     cpu_wr_ready,
  input  logic [ADDR_W-1:0]        cpu_wr_addr,
  input  logic [7:0]               cpu_wr_data,
  output logic [ADDR_W-1:0]        vram_addr,
  output logic [7:0]               vram_wdata,
  output logic                     vram_we,
  output logic                     gpu_owns,
  output logic [$clog2(DEPTH):0]   pending,
  output logic                     vblank_irq,
  input  logic                     irq_ack
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  localparam logic [1:0] ST_GPU  = 2'd0;
  localparam logic [1:0] ST_TURN = 2'd1;
  localparam logic [1:0] ST_CPU  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [PW-1:0]     wptr_q, rptr_q;
  logic [CW-1:0]     count_q, count_d;
  logic              vsync_q;
  logic              irq_q, irq_d;
  logic              push, pop;

  logic [ADDR_W-1:0] addr_mem_q [DEPTH];
  logic [7:0]        data_mem_q [DEPTH];

  // Outputs that must hold their reset values while rst is high are gated
  // combinationally, since the registers only take reset on the next edge.
  assign cpu_wr_ready = !rst && (count_q < DEPTH_C);
  assign push         = cpu_wr_valid && cpu_wr_ready;
  // Qualifying with the live visible input stops a write in the very cycle
  // visible rises, before the FSM has had a chance to leave CPU.
  assign pop          = !rst && (state_q == ST_CPU) && !visible && (count_q != '0);
  assign vram_we      = pop;
  assign gpu_owns     = rst || (state_q != ST_CPU);
  assign pending      = count_q;
  assign vblank_irq   = irq_q;

  // Head entry; only meaningful while vram_we is high.
  assign vram_addr    = addr_mem_q[rptr_q];
  assign vram_wdata   = data_mem_q[rptr_q];

  // TURN is a one-cycle guard between the GPU releasing VRAM and CPU writes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_GPU:  if (!visible) state_d = ST_TURN;
      ST_TURN: state_d = visible ? ST_GPU : ST_CPU;
      ST_CPU:  if (visible) state_d = ST_GPU;
      default: state_d = ST_GPU;
    endcase
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // A new falling edge of vsync takes priority over an acknowledge.
  always_comb begin
    irq_d = irq_q;
    if (vsync_q && !vsync) begin
      irq_d = 1'b1;
    end else if (irq_ack) begin
      irq_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_GPU;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      vsync_q <= 1'b1;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      vsync_q <= vsync;
      irq_q   <= irq_d;
      // DEPTH is a power of two, so pointer overflow is the modulo wrap.
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop)  rptr_q <= rptr_q + PW'(1);
    end
  end

  // Storage needs no reset; entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem_q[wptr_q] <= cpu_wr_addr;
      data_mem_q[wptr_q] <= cpu_wr_data;
    end
  end

endmodule

// File: tb/tb_vram_write_scheduler.sv
module tb_vram_write_scheduler;

  localparam int ADDR_W = 12;
  localparam int DEPTH  = 4;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic              clk;
  logic              rst;
  logic              visible;
  logic              vsync;
  logic              cpu_wr_valid;
  logic              cpu_wr_ready;
  logic [ADDR_W-1:0] cpu_wr_addr;
  logic [7:0]        cpu_wr_data;
  logic [ADDR_W-1:0] vram_addr;
  logic [7:0]        vram_wdata;
  logic              vram_we;
  logic              gpu_owns;
  logic [CW-1:0]     pending;
  logic              vblank_irq;
  logic              irq_ack;

  int checks = 0;
  int errors = 0;

  vram_write_scheduler #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .visible(visible), .vsync(vsync),
    .cpu_wr_valid(cpu_wr_valid), .cpu_wr_ready(cpu_wr_ready),
    .cpu_wr_addr(cpu_wr_addr), .cpu_wr_data(cpu_wr_data),
    .vram_addr(vram_addr), .vram_wdata(vram_wdata), .vram_we(vram_we),
    .gpu_owns(gpu_owns), .pending(pending),
    .vblank_irq(vblank_irq), .irq_ack(irq_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a queue of pending writes, the number of consecutive
  // blanking samples since the last visible sample (CPU owns after two),
  // and the interrupt flag with the previous vsync sample.
  logic [ADDR_W+7:0] q[$];
  int                low_run = 0;
  logic              m_irq = 1'b0;
  logic              m_prev_vs = 1'b1;

  logic              e_ready, e_we, e_gpu, e_irq;
  logic [CW-1:0]     e_pend;
  logic [ADDR_W-1:0] e_addr;
  logic [7:0]        e_data;

  function automatic void model_outputs();
    e_ready = !rst && (q.size() < DEPTH);
    e_we    = !rst && (low_run >= 2) && !visible && (q.size() != 0);
    e_gpu   = rst || (low_run < 2);
    e_pend  = CW'(q.size());
    e_irq   = m_irq;
    e_addr  = '0;
    e_data  = '0;
    if (q.size() != 0) begin
      e_addr = q[0][ADDR_W+7:8];
      e_data = q[0][7:0];
    end
  endfunction

  task automatic drive(input logic r, input logic vis, input logic vs, input logic val,
                       input logic [ADDR_W-1:0] a, input logic [7:0] d, input logic ack);
    @(negedge clk);
    rst          = r;
    visible      = vis;
    vsync        = vs;
    cpu_wr_valid = val;
    cpu_wr_addr  = a;
    cpu_wr_data  = d;
    irq_ack      = ack;
    #1;
    model_outputs();
  endtask

  task automatic tick();
    logic [ADDR_W+7:0] tmp;
    @(posedge clk);
    if (rst) begin
      q.delete();
      low_run   = 0;
      m_irq     = 1'b0;
      m_prev_vs = 1'b1;
    end else begin
      if (e_we) tmp = q.pop_front();
      if (cpu_wr_valid && e_ready) q.push_back({cpu_wr_addr, cpu_wr_data});
      low_run = visible ? 0 : ((low_run < 2) ? low_run + 1 : 2);
      if (m_prev_vs && !vsync) m_irq = 1'b1;
      else if (irq_ack)        m_irq = 1'b0;
      m_prev_vs = vsync;
    end
  endtask

  task automatic test_reset();
    drive(1, 1, 1, 1, 12'h0, 8'h0, 0);
    checks++; if (cpu_wr_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", cpu_wr_ready); end
    checks++; if (vram_we !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", vram_we); end
    checks++; if (gpu_owns !== 1'b1) begin errors++; $display("FAIL reset_gpu_owns got %b want 1", gpu_owns); end
    tick();
    drive(1, 1, 1, 0, 12'h0, 8'h0, 0);
    checks++; if (pending !== '0) begin errors++; $display("FAIL reset_pending got %0d want 0", pending); end
    checks++; if (vblank_irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", vblank_irq); end
    tick();
    drive(0, 1, 1, 0, 12'h0, 8'h0, 0);
    checks++; if (cpu_wr_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got %b want 1", cpu_wr_ready); end
    tick();
  endtask

  task automatic test_ordered_drain();
    logic [ADDR_W-1:0] a [3];
    logic [7:0]        d [3];
    a[0] = 12'h010; a[1] = 12'h011; a[2] = 12'h012;
    d[0] = 8'hAA;   d[1] = 8'hBB;   d[2] = 8'hCC;
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 1, 1, a[i], d[i], 0);
      checks++; if (vram_we !== 1'b0) begin errors++; $display("FAIL drain_visible_we[%0d] got %b want 0", i, vram_we); end
      tick();
    end
    drive(0, 1, 1, 0, 12'h0, 8'h0, 0);
    checks++; if (pending !== CW'(3)) begin errors++; $display("FAIL drain_pending3 got %0d want 3", pending); end
    tick();
    drive(0, 0, 1, 0, 12'h0, 8'h0, 0);
    checks++; if (vram_we !== 1'b0) begin errors++; $display("FAIL drain_gpu_we got %b want 0", vram_we); end
    tick();
    drive(0, 0, 1, 0, 12'h0, 8'h0, 0);
    checks++; if (vram_we !== 1'b0 || gpu_owns !== 1'b1) begin errors++; $display("FAIL drain_turn we=%b gpu_owns=%b want 0/1", vram_we, gpu_owns); end
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 0, 12'h0, 8'h0, 0);
      checks++;
      if (vram_we !== 1'b1 || vram_addr !== a[i] || vram_wdata !== d[i] || gpu_owns !== 1'b0) begin
        errors++;
        $display("FAIL drain_write[%0d] we=%b addr=%h data=%h owns=%b want 1 %h %h 0", i, vram_we, vram_addr, vram_wdata, gpu_owns, a[i], d[i]);
      end
      tick();
    end
    drive(0, 0, 1, 0, 12'h0, 8'h0, 0);
    checks++; if (pending !== '0 || vram_we !== 1'b0) begin errors++; $display("FAIL drain_empty pending=%0d we=%b want 0 0", pending, vram_we); end
    tick();
  endtask

  task automatic test_full();
    for (int i = 0; i <= DEPTH; i++) begin
      drive(0, 1, 1, 1, ADDR_W'(12'h100 + i), 8'(8'h40 + i), 0);
      checks++;
      if (cpu_wr_ready !== (i < DEPTH)) begin errors++; $display("FAIL full_ready[%0d] got %b want %b", i, cpu_wr_ready, (i < DEPTH)); end
      tick();
    end
    drive(0, 1, 1, 0, 12'h0, 8'h0, 0);
    checks++; if (pending !== CW'(DEPTH)) begin errors++; $display("FAIL full_pending got %0d want %0d", pending, DEPTH); end
    tick();
  endtask

  task automatic test_visible_rise();
    drive(0, 0, 1, 0, 12'h0, 8'h0, 0); tick();
    drive(0, 0, 1, 0, 12'h0, 8'h0, 0); tick();
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 1, 0, 12'h0, 8'h0, 0);
      checks++;
      if (vram_we !== 1'b1 || vram_addr !== ADDR_W'(12'h100 + i) || vram_wdata !== 8'(8'h40 + i)) begin
        errors++; $display("FAIL rise_first[%0d] we=%b addr=%h data=%h", i, vram_we, vram_addr, vram_wdata);
      end
      tick();
    end
    drive(0, 1, 1, 0, 12'h0, 8'h0, 0);
    checks++; if (vram_we !== 1'b0) begin errors++; $display("FAIL rise_we got %b want 0", vram_we); end
    tick();
    drive(0, 1, 1, 0, 12'h0, 8'h0, 0);
    checks++; if (gpu_owns !== 1'b1 || pending !== CW'(2)) begin errors++; $display("FAIL rise_after owns=%b pending=%0d want 1 2", gpu_owns, pending); end
    tick();
    drive(0, 0, 1, 0, 12'h0, 8'h0, 0);
    checks++; if (vram_we !== 1'b0) begin errors++; $display("FAIL rise_gpu_we got %b want 0", vram_we); end
    tick();
    drive(0, 0, 1, 0, 12'h0, 8'h0, 0);
    checks++; if (vram_we !== 1'b0) begin errors++; $display("FAIL rise_turn_we got %b want 0", vram_we); end
    tick();
    for (int i = 2; i < 4; i++) begin
      drive(0, 0, 1, 0, 12'h0, 8'h0, 0);
      checks++;
      if (vram_we !== 1'b1 || vram_addr !== ADDR_W'(12'h100 + i) || vram_wdata !== 8'(8'h40 + i)) begin
        errors++; $display("FAIL rise_rest[%0d] we=%b addr=%h data=%h", i, vram_we, vram_addr, vram_wdata);
      end
      tick();
    end
    drive(0, 0, 1, 0, 12'h0, 8'h0, 0);
    checks++; if (pending !== '0) begin errors++; $display("FAIL rise_empty pending=%0d want 0", pending); end
    tick();
  endtask

  task automatic test_irq();
    drive(0, 1, 1, 0, 12'h0, 8'h0, 0); tick();
    drive(0, 1, 0, 0, 12'h0, 8'h0, 0);
    checks++; if (vblank_irq !== 1'b0) begin errors++; $display("FAIL irq_early got %b want 0", vblank_irq); end
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 0, 12'h0, 8'h0, 0);
      checks++; if (vblank_irq !== 1'b1) begin errors++; $display("FAIL irq_held[%0d] got %b want 1", i, vblank_irq); end
      tick();
    end
    drive(0, 1, 0, 0, 12'h0, 8'h0, 1); tick();
    drive(0, 1, 0, 0, 12'h0, 8'h0, 0);
    checks++; if (vblank_irq !== 1'b0) begin errors++; $display("FAIL irq_ack got %b want 0", vblank_irq); end
    tick();
    drive(0, 1, 1, 0, 12'h0, 8'h0, 0); tick();
    drive(0, 1, 0, 0, 12'h0, 8'h0, 1); tick();
    drive(0, 1, 0, 0, 12'h0, 8'h0, 0);
    checks++; if (vblank_irq !== 1'b1) begin errors++; $display("FAIL irq_set_wins got %b want 1", vblank_irq); end
    tick();
    drive(0, 1, 1, 0, 12'h0, 8'h0, 1); tick();
  endtask

  task automatic test_back_to_back();
    drive(0, 1, 1, 1, 12'h200, 8'h11, 0); tick();
    drive(0, 1, 1, 1, 12'h201, 8'h22, 0); tick();
    drive(0, 0, 1, 0, 12'h0, 8'h0, 0); tick();
    drive(0, 0, 1, 0, 12'h0, 8'h0, 0); tick();
    drive(0, 0, 1, 1, 12'h202, 8'h33, 0);
    checks++; if (vram_we !== 1'b1 || vram_addr !== 12'h200 || vram_wdata !== 8'h11) begin errors++; $display("FAIL b2b_0 we=%b addr=%h data=%h want 1 200 11", vram_we, vram_addr, vram_wdata); end
    tick();
    drive(0, 0, 1, 1, 12'h203, 8'h44, 0);
    checks++; if (pending !== CW'(2)) begin errors++; $display("FAIL b2b_pending got %0d want 2", pending); end
    checks++; if (vram_we !== 1'b1 || vram_addr !== 12'h201 || vram_wdata !== 8'h22) begin errors++; $display("FAIL b2b_1 we=%b addr=%h data=%h want 1 201 22", vram_we, vram_addr, vram_wdata); end
    tick();
    drive(0, 0, 1, 0, 12'h0, 8'h0, 0);
    checks++; if (pending !== CW'(2) || vram_addr !== 12'h202 || vram_wdata !== 8'h33) begin errors++; $display("FAIL b2b_2 pending=%0d addr=%h data=%h want 2 202 33", pending, vram_addr, vram_wdata); end
    tick();
    drive(0, 0, 1, 0, 12'h0, 8'h0, 0);
    checks++; if (vram_we !== 1'b1 || vram_addr !== 12'h203 || vram_wdata !== 8'h44) begin errors++; $display("FAIL b2b_3 we=%b addr=%h data=%h want 1 203 44", vram_we, vram_addr, vram_wdata); end
    tick();
    drive(0, 0, 1, 0, 12'h0, 8'h0, 0);
    checks++; if (pending !== '0) begin errors++; $display("FAIL b2b_empty pending=%0d want 0", pending); end
    tick();
  endtask

  task automatic test_reset_mid_drain();
    drive(0, 1, 0, 1, 12'h300, 8'h55, 0); tick();
    drive(0, 1, 0, 1, 12'h301, 8'h66, 0); tick();
    drive(0, 1, 0, 1, 12'h302, 8'h77, 0); tick();
    drive(0, 0, 0, 0, 12'h0, 8'h0, 0); tick();
    drive(0, 0, 0, 0, 12'h0, 8'h0, 0);
    checks++; if (pending !== CW'(3) || vblank_irq !== 1'b1) begin errors++; $display("FAIL mid_pre pending=%0d irq=%b want 3 1", pending, vblank_irq); end
    tick();
    drive(1, 0, 0, 0, 12'h0, 8'h0, 0);
    checks++; if (vram_we !== 1'b0) begin errors++; $display("FAIL mid_reset_we got %b want 0", vram_we); end
    tick();
    drive(0, 0, 0, 0, 12'h0, 8'h0, 0);
    checks++;
    if (pending !== '0 || vram_we !== 1'b0 || gpu_owns !== 1'b1 || vblank_irq !== 1'b0) begin
      errors++; $display("FAIL mid_after pending=%0d we=%b owns=%b irq=%b want 0 0 1 0", pending, vram_we, gpu_owns, vblank_irq);
    end
    tick();
  endtask

  task automatic test_random();
    logic vis_r, vs_r;
    vis_r = 1'b0;
    vs_r  = 1'b1;
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 7) == 0)  vis_r = ~vis_r;
      if ($urandom_range(0, 15) == 0) vs_r  = ~vs_r;
      drive(1'($urandom_range(0, 199) == 0), vis_r, vs_r, 1'($urandom_range(0, 1)),
            ADDR_W'($urandom), 8'($urandom), 1'($urandom_range(0, 9) == 0));
      checks++;
      if (cpu_wr_ready !== e_ready || vram_we !== e_we || gpu_owns !== e_gpu ||
          pending !== e_pend || vblank_irq !== e_irq) begin
        errors++;
        $display("FAIL rand[%0d] ready=%b we=%b owns=%b pend=%0d irq=%b want %b %b %b %0d %b",
                 n, cpu_wr_ready, vram_we, gpu_owns, pending, vblank_irq, e_ready, e_we, e_gpu, e_pend, e_irq);
      end
      if (e_we) begin
        checks++;
        if (vram_addr !== e_addr || vram_wdata !== e_data) begin
          errors++; $display("FAIL rand_data[%0d] addr=%h data=%h want %h %h", n, vram_addr, vram_wdata, e_addr, e_data);
        end
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; visible = 1'b1; vsync = 1'b1; cpu_wr_valid = 1'b0;
    cpu_wr_addr = '0; cpu_wr_data = '0; irq_ack = 1'b0;
    test_reset();
    test_ordered_drain();
    test_full();
    test_visible_rise();
    test_irq();
    test_back_to_back();
    test_reset_mid_drain();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
